// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, UART FSM states and the ALU helper shared by uart_alu_top.
// Build option: define UART_PARITY_EN for 11-bit frames with even parity.
// Leave it undefined for 10-bit frames with no parity bit.
package uart_alu_pkg;

    localparam int unsigned DEFAULT_BIT_CYCLES = 868;

    localparam logic [7:0] OP_ADD = 8'h0A;
    localparam logic [7:0] OP_SUB = 8'h0B;
    localparam logic [7:0] OP_AND = 8'h0C;
    localparam logic [7:0] OP_OR  = 8'h0D;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Carry and borrow are dropped, so results wrap modulo 256.
    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] op);
        logic [7:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronizes RX, receives one frame and flags it good or bad.
// Build option: UART_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_byte
    import uart_alu_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       busy
);
    localparam int unsigned CNT_W = $clog2(BIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             fall;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok;
`ifdef UART_PARITY_EN
    logic             par_q, par_d;

    assign par_ok = ~^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    assign fall = rx_prev_q & ~rx_sync_q;
    assign busy = (state_q != StIdle);
    assign data = shift_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (res) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state: start recheck at half a bit, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid   = 1'b0;
        err     = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
`ifdef UART_PARITY_EN
                    par_d   = rx_sync_q;
`endif
                    state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_sync_q && par_ok) valid = 1'b1;
                    else                     err   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_alu_top.sv
// uart_alu_top: 3-byte serial command (A, B, opcode) in, one 8-bit ALU result frame out.
// Build option: UART_PARITY_EN selects 11-bit frames with even parity on RX and TX.
module uart_alu_top
    import uart_alu_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned BIT_CYCLES = CLK_HZ / BAUD
) (
    input  logic clk,
    input  logic res,
    input  logic RX,
    input  logic en_TX_out,
    input  logic TX_flag,
    output logic TX,
    output logic en_RX_in,
    output logic RX_flag
);
    localparam int unsigned CNT_W = $clog2(BIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [7:0] rx_data;
    logic       rx_valid, rx_err;

    uart_rx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_rx (
        .clk  (clk),
        .res  (res),
        .rx   (RX),
        .data (rx_data),
        .valid(rx_valid),
        .err  (rx_err),
        .busy (en_RX_in)
    );

    logic [1:0] byte_cnt_q;
    logic [7:0] a_q, b_q, result_q;
    logic       flag_q;

    assign RX_flag = flag_q;

    // Command assembly: collect A and B, then evaluate on a valid opcode byte.
    always_ff @(posedge clk) begin
        if (res) begin
            byte_cnt_q <= 2'd0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            result_q   <= 8'h00;
            flag_q     <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            if (rx_err) begin
                byte_cnt_q <= 2'd0;
            end else if (rx_valid) begin
                case (byte_cnt_q)
                    2'd0: begin
                        a_q        <= rx_data;
                        byte_cnt_q <= 2'd1;
                    end
                    2'd1: begin
                        b_q        <= rx_data;
                        byte_cnt_q <= 2'd2;
                    end
                    default: begin
                        byte_cnt_q <= 2'd0;
                        if (op_valid(rx_data)) begin
                            result_q <= alu(a_q, b_q, rx_data);
                            flag_q   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    // Disable overrides the line at once, without waiting for the register.
    assign TX = tx_q | ~en_TX_out;

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (res) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // Next state: tx_d is the level for the next bit, loaded at each bit boundary.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == BIT_LAST) ? '0 : tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            StIdle: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                // A result arriving while busy never reaches here and is dropped.
                if (flag_q && TX_flag) begin
                    tx_state_d = StStart;
                    tx_shift_d = result_q;
                    tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^result_q;
`endif
                end
            end
            StStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = StData;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            StData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = StParity;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = StStop;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_d = tx_shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = StStop;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = StIdle;
                    tx_d       = 1'b1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
        if (!en_TX_out) begin
            tx_state_d = StIdle;
            tx_cnt_d   = '0;
            tx_d       = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_alu_top.sv
// tb_uart_alu_top: serial command driver, independent TX frame decoder and result model.
// Bit period is shortened so the whole run stays small; frame format follows UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_alu_top;
    localparam int unsigned BIT = 16;
`ifdef UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic clk = 1'b0;
    logic res, RX, en_TX_out, TX_flag;
    logic TX, en_RX_in, RX_flag;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_flag_cyc = 32'hFFFF_0000;
    int unsigned flag_cnt = 0;
    int unsigned exp_flags = 0;
    int unsigned tx_lows = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          abort_phase = 1'b0;

    uart_alu_top #(
        .BIT_CYCLES(BIT)
    ) dut (
        .clk      (clk),
        .res      (res),
        .RX       (RX),
        .en_TX_out(en_TX_out),
        .TX_flag  (TX_flag),
        .TX       (TX),
        .en_RX_in (en_RX_in),
        .RX_flag  (RX_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flag pulses and TX-low cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (RX_flag === 1'b1) begin
            flag_cnt++;
            last_flag_cyc = cyc;
        end
        if (TX !== 1'b1) tx_lows++;
    end

    // Frame decoder: samples the TX line at mid-bit from its falling edge.
    initial begin : tx_decoder
        logic [7:0]  d;
        logic        s;
        int unsigned t0;
`ifdef UART_PARITY_EN
        logic        p;
`endif
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                t0 = cyc;
                chk("tx_start_latency", t0, last_flag_cyc + 1);
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = TX;
                end
`ifdef UART_PARITY_EN
                repeat (BIT) @(negedge clk);
                p = TX;
`endif
                repeat (BIT) @(negedge clk);
                s = TX;
                if (!abort_phase) begin
                    got_q.push_back(d);
`ifdef UART_PARITY_EN
                    chk("tx_parity", {31'd0, p}, {31'd0, ^d});
`endif
                    chk("tx_stop", {31'd0, s}, 32'd1);
                end
                repeat (BIT / 2 - 1) @(negedge clk);
            end
        end
    end

    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            'h0A:    return (a + b) % 256;
            'h0B:    return (a - b + 256) % 256;
            'h0C:    return a & b;
            'h0D:    return a | b;
            default: return -1;
        endcase
    endfunction

    task automatic send_bit(input logic v);
        RX = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        chk("en_rx_busy", {31'd0, en_RX_in}, 32'd1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
        send_bit((^b) ^ bad_par);
`endif
        send_bit(!bad_stop);
        if (bad_stop) begin
            send_bit(1'b1);
            chk("en_rx_idle_after_err", {31'd0, en_RX_in}, 32'd0);
        end
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int r;
        send_byte(a, 1'b0, 1'b0);
        send_byte(b, 1'b0, 1'b0);
        send_byte(op, 1'b0, 1'b0);
        r = ref_alu(int'(a), int'(b), int'(op));
        if (r >= 0) begin
            exp_flags++;
            if (TX_flag && en_TX_out) exp_q.push_back(8'(r));
        end
    endtask

    task automatic wait_tx();
        repeat ((NB + 2) * BIT) @(negedge clk);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        chk("rx_flag_count", flag_cnt, exp_flags);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  a, b, op;
        logic [7:0]  dir_exp[4];
        int unsigned low0, bad;

        dir_exp = '{8'h1D, 8'h01, 8'h0E, 8'h0F};
        RX = 1'b1;
        res = 1'b1;
        en_TX_out = 1'b1;
        TX_flag = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_tx", {31'd0, TX}, 32'd1);
        chk("reset_en_rx", {31'd0, en_RX_in}, 32'd0);
        chk("reset_rx_flag", {31'd0, RX_flag}, 32'd0);
        res = 1'b0;

        bad = 0;
        repeat (20 * BIT) begin
            @(negedge clk);
            if (TX !== 1'b1 || en_RX_in !== 1'b0 || RX_flag !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Fixed command set, sent with no gap between frames.
        run_cmd(8'h0F, 8'h0E, 8'h0A);
        run_cmd(8'h0F, 8'h0E, 8'h0B);
        run_cmd(8'h0F, 8'h0E, 8'h0C);
        run_cmd(8'h0F, 8'h0E, 8'h0D);
        wait_tx();
        chk("directed_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("directed_result", (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF,
                {24'd0, dir_exp[i]});
        chk("rx_flag_count", flag_cnt, exp_flags);
        got_q.delete();
        exp_q.delete();

        // Random operands, mostly valid opcodes, occasional TX_flag=0.
        for (int n = 0; n < 8; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 4) op = 8'($urandom_range(14, 255));
            else                           op = 8'(8'h0A + $urandom_range(0, 3));
            TX_flag = ($urandom_range(0, 3) != 0);
            run_cmd(a, b, op);
        end
        wait_tx();
        check_results("random");
        TX_flag = 1'b1;

`ifdef UART_PARITY_EN
        // Bad parity on byte1 discards the partial command.
        send_byte(8'($urandom), 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b1, 1'b0);
        run_cmd(8'h33, 8'h55, 8'h0A);
        wait_tx();
        check_results("parity_err");
`endif
        // Bad stop bit on byte1 discards the partial command.
        send_byte(8'($urandom), 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b1);
        run_cmd(8'h10, 8'h20, 8'h0B);
        wait_tx();
        check_results("stop_err");

        // Invalid opcode, then a valid command with TX_flag low: nothing on TX.
        low0 = tx_lows;
        run_cmd(8'($urandom), 8'($urandom), 8'h10);
        TX_flag = 1'b0;
        run_cmd(8'h44, 8'h11, 8'h0D);
        wait_tx();
        chk("no_tx_activity", tx_lows - low0, 0);
        check_results("dropped");
        TX_flag = 1'b1;

        // Reset during transmission.
        run_cmd(8'hF0, 8'h0F, 8'h0D);
        repeat (3 * BIT) @(negedge clk);
        abort_phase = 1'b1;
        res = 1'b1;
        @(negedge clk);
        chk("reset_abort_tx", {31'd0, TX}, 32'd1);
        chk("reset_abort_en_rx", {31'd0, en_RX_in}, 32'd0);
        res = 1'b0;
        low0 = tx_lows;
        repeat (2 * BIT) @(negedge clk);
        chk("reset_abort_idle", tx_lows - low0, 0);
        wait_tx();
        got_q.delete();
        exp_q.delete();
        abort_phase = 1'b0;
        run_cmd(8'h80, 8'h81, 8'h0A);
        wait_tx();
        check_results("after_reset");

        // Transmitter disabled during transmission.
        run_cmd(8'h5A, 8'hA5, 8'h0C);
        repeat (3 * BIT) @(negedge clk);
        abort_phase = 1'b1;
        en_TX_out = 1'b0;
        @(negedge clk);
        chk("disable_abort_tx", {31'd0, TX}, 32'd1);
        en_TX_out = 1'b1;
        low0 = tx_lows;
        repeat (2 * BIT) @(negedge clk);
        chk("disable_abort_idle", tx_lows - low0, 0);
        wait_tx();
        got_q.delete();
        exp_q.delete();
        abort_phase = 1'b0;
        run_cmd(8'h03, 8'h07, 8'h0B);
        wait_tx();
        check_results("after_disable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
